branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the five-stage pipelined CPU: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. It sits directly upstream of the next-PC 2:1 select in IF, supplying a predicted target and the select bit. It also resolves branches reported from EX, producing the mispredict flush/redirect that drives the correction-path select. Hit and miss statistics are kept for the lab's performance report.

## Interface
Parameters:
- ENTRY_BITS, 4, log2 of entry count (16 entries)
- WIDTH, 32, address/data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_if  input  WIDTH  PC currently in IF
- pred_taken  output  1  IF prediction; select bit for the next-PC mux
- pred_target  output  WIDTH  predicted target; 0 when pred_taken=0
- upd_valid  input  1  EX holds a resolved conditional branch this cycle
- upd_pc  input  WIDTH  PC of that branch
- upd_taken  input  1  actual outcome
- upd_target  input  WIDTH  actual taken target
- ex_pred_taken  input  1  prediction carried down the pipeline with the branch
- ex_pred_target  input  WIDTH  target carried down with the branch
- mispredict  output  1  flush IF/ID and ID/EX, select redirect_pc
- redirect_pc  output  WIDTH  corrected fetch address
- branch_cnt  output  32  resolved branches since reset
- miss_cnt  output  32  mispredicts since reset

## Operation
- Entry fields: valid, tag, target, ctr[1:0]. index = pc[ENTRY_BITS+1:2]; tag = pc[WIDTH-1:ENTRY_BITS+2]; pc[1:0] ignored.
- Prediction (combinational from pc_if): hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = entry target when pred_taken, else 0.
- Update, at rising edge when upd_valid=1, addressed by upd_pc:
  - Hit and taken: ctr saturating increment (max 2'b11); target := upd_target.
  - Hit and not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss (invalid or tag mismatch) and taken: allocate/replace with valid=1, new tag, target=upd_target, ctr=2'b10.
  - Miss and not taken: no table change.
- Resolution is combinational and is forced to 0 when upd_valid=0:
  - mispredict = upd_valid & ((ex_pred_taken != upd_taken) | (ex_pred_taken & upd_taken & ex_pred_target != upd_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc + 4. It is 0 when mispredict=0.
- Counters: branch_cnt += 1 on every upd_valid cycle. miss_cnt += 1 when mispredict=1. Both are 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- Prediction latency is zero: same cycle as pc_if.
- Table updates become visible on the cycle after the update edge.
- Simultaneous IF read and EX update to the same index: IF sees the pre-update contents.
- Reset behaviour:
  - rst=1 at an edge clears all valid bits, sets all ctr to 2'b01 and clears both counters.
  - rst overrides an update presented in the same cycle.
  - Outputs while rst=1 follow the cleared state: pred_taken=0, pred_target=0, and mispredict/redirect_pc reflect only upd_* inputs.
  - The pipeline is responsible for holding upd_valid=0 during reset.
- Reset mid-operation loses all history; there is no partial state.
- No stall input. The pipeline asserts upd_valid exactly once per branch, in the EX cycle that is not itself being flushed.

## Test plan
- Reset, then pc_if=0x00000040 -> pred_taken=0, pred_target=0. Pulse upd_valid with upd_pc=0x40, not taken, ex_pred_taken=0 -> mispredict=0, branch_cnt=1, miss_cnt=0, next-cycle prediction still 0.
- Cold taken branch: upd_pc=0x40, upd_taken=1, upd_target=0x100, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle pc_if=0x40 gives pred_taken=1, pred_target=0x100 (ctr=10).
- Saturation:
  - Three more taken updates -> ctr=11.
  - Two not-taken updates -> ctr=01, pred_taken=0.
  - Two further not-taken updates -> ctr stays 00.
  - A single taken update -> ctr=01, still predicts not taken.
- Alias and wrong target:
  - upd_pc=0x440 (same index, different tag) taken to 0x200 replaces the 0x40 entry; pc_if=0x40 then misses.
  - ex_pred_taken=1, ex_pred_target=0x100, upd_target=0x200 -> mispredict=1, redirect_pc=0x200.
- Not-taken mispredict and same-cycle read/write: ex_pred_taken=1, upd_taken=0, upd_pc=0x80 -> redirect_pc=0x84. With pc_if=0x80 in that same cycle, pred_taken equals the old entry value.
- Counters:
  - Preload miss_cnt=0xFFFFFFFF via a forced bench value, then one mispredict -> miss_cnt=0.
  - Assert rst together with upd_valid -> no table write, both counters 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute signal bundle between the CPU pipeline and the branch predictor.
// The pipeline side drives PCs and resolved outcomes; the predictor side answers.
interface branch_predictor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc_if;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;
  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_taken;
  logic [WIDTH-1:0] upd_target;
  logic             ex_pred_taken;
  logic [WIDTH-1:0] ex_pred_target;
  logic             mispredict;
  logic [WIDTH-1:0] redirect_pc;
  logic [31:0]      branch_cnt;
  logic [31:0]      miss_cnt;

  modport master (
    output pc_if, upd_valid, upd_pc, upd_taken, upd_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, miss_cnt
  );

  modport slave (
    input  pc_if, upd_valid, upd_pc, upd_taken, upd_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF prediction,
// EX-side resolution with mispredict redirect, and hit/miss statistics.
module branch_predictor #(
  parameter int ENTRY_BITS = 4,
  parameter int WIDTH      = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = WIDTH - ENTRY_BITS - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // IF read port; masked during reset so fetch sees the cleared table
  logic [ENTRY_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_hit;

  assign rd_idx         = bp.pc_if[ENTRY_BITS+1:2];
  assign rd_tag         = bp.pc_if[WIDTH-1:ENTRY_BITS+2];
  assign rd_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign bp.pred_taken  = !rst && rd_hit && ctr_q[rd_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[rd_idx] : '0;

  logic unused_lsbs;
  assign unused_lsbs = ^{bp.pc_if[1:0], bp.upd_pc[1:0]};

  // EX update port
  logic [ENTRY_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic                  ent_we;
  logic [TAG_W-1:0]      ent_tag_d;
  logic [WIDTH-1:0]      ent_tgt_d;
  logic [1:0]            ent_ctr_d;

  assign up_idx = bp.upd_pc[ENTRY_BITS+1:2];
  assign up_tag = bp.upd_pc[WIDTH-1:ENTRY_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ent_we    = 1'b0;
    ent_tag_d = tag_q[up_idx];
    ent_tgt_d = target_q[up_idx];
    ent_ctr_d = ctr_q[up_idx];
    if (bp.upd_valid) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (bp.upd_taken) begin
          ent_ctr_d = sat_inc(ctr_q[up_idx]);
          ent_tgt_d = bp.upd_target;
        end else begin
          ent_ctr_d = sat_dec(ctr_q[up_idx]);
        end
      end else if (bp.upd_taken) begin
        // a taken miss allocates (or evicts an alias) weakly-taken
        ent_we    = 1'b1;
        ent_tag_d = up_tag;
        ent_tgt_d = bp.upd_target;
        ent_ctr_d = 2'b10;
      end
    end
  end

  // Resolution against what the pipeline actually fetched
  logic mispredict_w;

  assign mispredict_w = bp.upd_valid &&
                        ((bp.ex_pred_taken != bp.upd_taken) ||
                         (bp.ex_pred_taken && bp.upd_taken &&
                          (bp.ex_pred_target != bp.upd_target)));
  assign bp.mispredict  = mispredict_w;
  assign bp.redirect_pc = !mispredict_w ? '0 :
                          (bp.upd_taken ? bp.upd_target : bp.upd_pc + WIDTH'(4));

  assign branch_cnt_d  = branch_cnt_q + 32'(bp.upd_valid);
  assign miss_cnt_d    = miss_cnt_q + 32'(mispredict_w);
  assign bp.branch_cnt = branch_cnt_q;
  assign bp.miss_cnt   = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (ent_we) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= ent_tag_d;
        target_q[up_idx] <= ent_tgt_d;
        ctr_q[up_idx]    <= ent_ctr_d;
      end
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: directed scenarios then random traffic
// against a table model built directly from the prediction/update rules.
module tb_branch_predictor;
  localparam int W  = 32;
  localparam int EB = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(W)) bp ();
  branch_predictor #(.ENTRY_BITS(EB), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bp(bp));

  typedef struct packed {
    logic        cnt_known;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference table: one slot per index, tag is the PC above the index bits
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  logic [31:0] m_bc, m_mc;
  bit          m_known = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pred_taken", 32'(bp.pred_taken), 32'(e.pt));
      chk("pred_target", bp.pred_target, e.ptg);
      chk("mispredict", 32'(bp.mispredict), 32'(e.mp));
      chk("redirect_pc", bp.redirect_pc, e.rpc);
      if (e.cnt_known) begin
        chk("branch_cnt", bp.branch_cnt, e.bc);
        chk("miss_cnt", bp.miss_cnt, e.mc);
      end
    end
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  task automatic model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    t  = m_v[i] && (m_tag[i] == (pc >> (EB + 2))) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : 32'h0;
  endtask

  // drive one cycle, predict outputs, then advance the model across the edge
  task automatic cycle(input logic r, input logic [31:0] pcif, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                       input logic ept, input logic [31:0] eptg);
    exp_t        e;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    int          i;
    bit          hit;
    rst = r;
    bp.pc_if = pcif;
    bp.upd_valid = uv;
    bp.upd_pc = upc;
    bp.upd_taken = ut;
    bp.upd_target = utg;
    bp.ex_pred_taken = ept;
    bp.ex_pred_target = eptg;
    model_pred(pcif, pt, ptg);
    if (r) begin
      pt  = 1'b0;
      ptg = 32'h0;
    end
    mp = uv && ((ept != ut) || (ept && ut && (eptg != utg)));
    e.cnt_known = m_known;
    e.pt  = pt;
    e.ptg = ptg;
    e.mp  = mp;
    e.rpc = !mp ? 32'h0 : (ut ? utg : upc + 32'd4);
    e.bc  = m_bc;
    e.mc  = m_mc;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < N; k++) begin
        m_v[k]   = 0;
        m_ctr[k] = 1;
      end
      m_bc = 0;
      m_mc = 0;
      m_known = 1;
    end else begin
      if (uv) begin
        i   = idx_of(upc);
        hit = m_v[i] && (m_tag[i] == (upc >> (EB + 2)));
        if (hit && ut) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = utg;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (ut) begin
          m_v[i]   = 1;
          m_tag[i] = upc >> (EB + 2);
          m_tgt[i] = utg;
          m_ctr[i] = 2;
        end
      end
      m_bc = m_bc + 32'(uv);
      m_mc = m_mc + 32'(mp);
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] pcif);
    cycle(1'b0, pcif, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pcif, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utg, input logic ept, input logic [31:0] eptg);
    cycle(1'b0, pcif, 1'b1, upc, ut, utg, ept, eptg);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc, tg, eptg;
    logic        t, ept, ut, uv, r;
    rst = 1'b1;
    bp.pc_if = '0; bp.upd_valid = 1'b0; bp.upd_pc = '0; bp.upd_taken = 1'b0;
    bp.upd_target = '0; bp.ex_pred_taken = 1'b0; bp.ex_pred_target = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h40);

    // not-taken cold branch, then cold taken allocation
    upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h40);
    upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    idle(32'h40);

    // saturate up, walk down to 00, single taken back to 01
    for (int k = 0; k < 3; k++) upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    idle(32'h40);
    for (int k = 0; k < 4; k++) upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    idle(32'h40);

    // alias eviction and wrong-target mispredict
    upd(32'h40, 32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
    idle(32'h40);
    idle(32'h440);
    upd(32'h40, 32'h440, 1'b1, 32'h200, 1'b1, 32'h100);

    // not-taken mispredict with a same-cycle read of the updated entry
    upd(32'h80, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    upd(32'h80, 32'h80, 1'b0, 32'h0, 1'b1, 32'h300);
    idle(32'h80);

    // miss counter wrap
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    m_mc = 32'hFFFF_FFFF;
    upd(32'h80, 32'h90, 1'b1, 32'h400, 1'b0, 32'h0);
    idle(32'h90);

    // reset wins over a coincident update
    cycle(1'b1, 32'h90, 1'b1, 32'h90, 1'b1, 32'h500, 1'b0, 32'h0);
    idle(32'h90);

    // random traffic over a few indices and aliasing tags
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      uv = !r && ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 2) << (EB + 2)) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      ut = $urandom_range(0, 1);
      tg = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h200;
      if ($urandom_range(0, 1) != 0) begin
        model_pred(pc, ept, eptg);
      end else begin
        ept  = $urandom_range(0, 1);
        eptg = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h200;
      end
      cycle(r, ($urandom_range(0, 2) << (EB + 2)) | ($urandom_range(0, 3) << 2),
            uv, pc, ut, tg, ept, eptg);
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
